// File: rtl/fma16_arbiter_if.sv
// Handshake bundle between the requesters and the shared fma16 arbiter.
// Requesters drive the master side; the arbiter implements the slave side.
interface fma16_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_x;
    logic [NREQ*16-1:0] req_y;
    logic [NREQ*16-1:0] req_z;
    logic [NREQ*6-1:0]  req_ctrl;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_result;
    logic [3:0]         rsp_flags;
    logic [NREQ*4-1:0]  sticky_flags;
    logic [NREQ-1:0]    flags_clr;

    modport master (
        output req_valid, req_x, req_y, req_z, req_ctrl,
        output rsp_ready, flags_clr,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
        input  rsp_flags, sticky_flags
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_ctrl,
        input  rsp_ready, flags_clr,
        output req_ready, rsp_valid, rsp_id, rsp_result,
        output rsp_flags, sticky_flags
    );
endinterface

// File: rtl/fma16_arbiter.sv
// Round-robin share of one combinational fma16 datapath between NREQ
// requesters: issue register, fma16, response register, sticky flags.
module fma16_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic            clk,
    input logic            reset,
    fma16_arbiter_if.slave bus
);
    localparam int MW = 82;

    logic           a_v;
    logic [IDW-1:0] a_id;
    logic [15:0]    a_x, a_y, a_z;
    logic [5:0]     a_ctrl;
    logic [IDW-1:0] ptr, winner;
    logic           found, adv_b, a_free, accept, hs;
    logic [15:0]    f_res;
    logic [3:0]     f_flags;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                winner = IDW'((int'(ptr) + k) % NREQ);
                found  = 1'b1;
            end
        end
    end

    assign adv_b  = a_v & (~bus.rsp_valid | bus.rsp_ready);
    assign a_free = ~a_v | adv_b;
    assign accept = a_free & (|bus.req_valid) & ~reset;
    assign hs     = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        bus.req_ready = '0;
        if (accept)
            bus.req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_v    <= 1'b0;
            a_id   <= '0;
            a_x    <= '0;
            a_y    <= '0;
            a_z    <= '0;
            a_ctrl <= '0;
            ptr    <= '0;
        end else if (accept) begin
            a_v    <= 1'b1;
            a_id   <= winner;
            a_x    <= bus.req_x[16*winner +: 16];
            a_y    <= bus.req_y[16*winner +: 16];
            a_z    <= bus.req_z[16*winner +: 16];
            a_ctrl <= bus.req_ctrl[6*winner +: 6];
            ptr    <= (int'(winner) == NREQ-1) ? '0 : winner + 1'b1;
        end else if (adv_b) begin
            a_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_result   <= '0;
            bus.rsp_flags    <= '0;
            bus.sticky_flags <= '0;
        end else begin
            if (adv_b) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_id     <= a_id;
                bus.rsp_result <= f_res;
                bus.rsp_flags  <= f_flags;
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
            // clear first, then merge the flags of this cycle's handshake
            for (int i = 0; i < NREQ; i++) begin
                bus.sticky_flags[4*i +: 4] <=
                    (bus.flags_clr[i] ? 4'b0 : bus.sticky_flags[4*i +: 4]) |
                    ((hs && int'(bus.rsp_id) == i) ? bus.rsp_flags : 4'b0);
            end
        end
    end

    logic [1:0]  rm;
    logic        op_mul, op_add, negp, negz;
    logic [15:0] fy, fz;
    logic [4:0]  xe, ye, ze, xee, yee, zee;
    logic [10:0] xm, ym, zm;
    logic        ps, zsn;
    logic        x_nan, y_nan, z_nan, x_inf, y_inf, z_inf;
    logic        x_zero, y_zero, p_inf, snan, any_nan, inv;

    assign {rm, op_mul, op_add, negp, negz} = a_ctrl;
    assign fy = op_mul ? a_y : 16'h3C00;
    assign fz = op_add ? a_z : 16'h0000;

    assign xe  = a_x[14:10];
    assign ye  = fy[14:10];
    assign ze  = fz[14:10];
    assign xee = xe | {4'b0, ~|xe};
    assign yee = ye | {4'b0, ~|ye};
    assign zee = ze | {4'b0, ~|ze};
    assign xm  = {|xe, a_x[9:0]};
    assign ym  = {|ye, fy[9:0]};
    assign zm  = {|ze, fz[9:0]};
    assign ps  = a_x[15] ^ fy[15] ^ negp;
    assign zsn = fz[15] ^ negz;

    assign x_nan  = (&xe) & (|a_x[9:0]);
    assign y_nan  = (&ye) & (|fy[9:0]);
    assign z_nan  = (&ze) & (|fz[9:0]);
    assign x_inf  = (&xe) & ~(|a_x[9:0]);
    assign y_inf  = (&ye) & ~(|fy[9:0]);
    assign z_inf  = (&ze) & ~(|fz[9:0]);
    assign x_zero = ~|a_x[14:0];
    assign y_zero = ~|fy[14:0];
    assign p_inf  = x_inf | y_inf;
    assign any_nan = x_nan | y_nan | z_nan;
    assign snan = (x_nan & ~a_x[9]) | (y_nan & ~fy[9]) | (z_nan & ~fz[9]);
    assign inv  = (x_inf & y_zero) | (y_inf & x_zero) |
                  (p_inf & z_inf & (ps ^ zsn)) | snan;

    // exact sum in fixed point, LSB weight 2^-48
    logic [21:0]   pm;
    logic [5:0]    pshift, zshift;
    logic [MW-1:0] pmag, zmag, mag, shifted;
    logic          rs;
    logic [6:0]    lead, sh, ebase;
    logic [19:0]   enc, rnd;
    logic          tiny, rbit, sbit, inx, inc, to_inf;
    logic          unused_bits;

    assign pm     = xm * ym;
    assign pshift = {1'b0, xee} + {1'b0, yee} - 6'd2;
    assign zshift = {1'b0, zee} + 6'd23;
    assign pmag   = {60'b0, pm} << pshift;
    assign zmag   = {71'b0, zm} << zshift;

    always_comb begin
        mag = '0;
        rs  = ps;
        if (ps == zsn) begin
            mag = pmag + zmag;
        end else if (pmag >= zmag) begin
            mag = pmag - zmag;
        end else begin
            mag = zmag - pmag;
            rs  = zsn;
        end
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < MW; i++)
            if (mag[i]) lead = 7'(i);
    end

    assign tiny    = lead < 7'd34;
    assign sh      = tiny ? 7'd24 : lead - 7'd10;
    assign ebase   = tiny ? 7'd0 : lead - 7'd34;
    assign shifted = mag >> sh;
    assign enc     = {3'b0, ebase, 10'b0} + {9'b0, shifted[10:0]};
    assign rbit    = mag[sh - 7'd1];
    assign sbit    = |(mag & ((MW'(1) << (sh - 7'd1)) - MW'(1)));
    assign inx     = rbit | sbit;
    assign rnd     = enc + {19'b0, inc};
    assign to_inf  = (rm == 2'b01) | ((rm == 2'b10) & rs) |
                     ((rm == 2'b11) & ~rs);
    assign unused_bits = ^shifted[MW-1:11];

    always_comb begin
        inc = 1'b0;
        unique case (rm)
            2'b00: inc = 1'b0;
            2'b01: inc = rbit & (sbit | shifted[0]);
            2'b10: inc = inx & rs;
            2'b11: inc = inx & ~rs;
        endcase
    end

    always_comb begin
        f_res   = '0;
        f_flags = '0;
        if (any_nan | inv) begin
            f_res   = 16'h7E00;
            f_flags = {inv, 3'b000};
        end else if (p_inf) begin
            f_res = {ps, 15'h7C00};
        end else if (z_inf) begin
            f_res = {zsn, 15'h7C00};
        end else if (mag == '0) begin
            f_res = {(ps == zsn) ? ps : (rm == 2'b10), 15'h0000};
        end else if (rnd >= 20'h07C00) begin
            f_res   = {rs, to_inf ? 15'h7C00 : 15'h7BFF};
            f_flags = 4'b0101;
        end else begin
            f_res   = {rs, rnd[14:0]};
            f_flags = {2'b00, tiny & inx, inx};
        end
    end
endmodule

// File: tb/tb_fma16_arbiter.sv
// Directed bench for fma16_arbiter: vector table through single requesters
// plus sequences for round-robin, backpressure, flag clearing and reset.
module tb_fma16_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   acc;

    fma16_arbiter_if #(.NREQ(2)) bus ();
    fma16_arbiter #(.NREQ(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [15:0] x, y, z;
        logic [5:0]  c;
        logic [15:0] er;
        logic [3:0]  ef;
    } vec_t;

    vec_t        tbl [16];
    logic [3:0]  st [2];
    int          got_id [$];
    logic [15:0] got_res [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [15:0] x, y, z,
                          input logic [5:0] c);
        bus.req_x[16*r +: 16] = x;
        bus.req_y[16*r +: 16] = y;
        bus.req_z[16*r +: 16] = z;
        bus.req_ctrl[6*r +: 6] = c;
    endtask

    task automatic collect();
        if (bus.rsp_valid) begin
            got_id.push_back(int'(bus.rsp_id));
            got_res.push_back(bus.rsp_result);
        end
    endtask

    task automatic run_op(input int r, input logic [15:0] x, y, z,
                          input logic [5:0] c, input logic [15:0] er,
                          input logic [3:0] ef, input logic clr);
        int n;
        set_op(r, x, y, z, c);
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[r] && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 1, 0);
            bus.req_valid = '0;
            return;
        end
        step();
        bus.req_valid = '0;
        chk("lat_early", bus.rsp_valid, 0);
        chk("issue_no_flags", bus.sticky_flags, {st[1], st[0]});
        step();
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, r);
        chk("rsp_result", bus.rsp_result, er);
        chk("rsp_flags", bus.rsp_flags, ef);
        if (clr) bus.flags_clr[r] = 1'b1;
        step();
        bus.flags_clr = '0;
        st[r] = clr ? ef : (st[r] | ef);
        chk("sticky", bus.sticky_flags, {st[1], st[0]});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_z = '0;
        bus.req_ctrl = '0;
        bus.rsp_ready = 1'b0;
        bus.flags_clr = '0;
        st[0] = 4'h0;
        st[1] = 4'h0;

        tbl[0]  = '{0, 16'h3C00, 16'h4000, 16'h3C00, 6'b001100, 16'h4200, 4'b0000};
        tbl[1]  = '{1, 16'h7BFF, 16'h7BFF, 16'h0000, 6'b001100, 16'h7BFF, 4'b0101};
        tbl[2]  = '{0, 16'h7C00, 16'h0000, 16'h0000, 6'b001100, 16'h7E00, 4'b1000};
        tbl[3]  = '{1, 16'h3C00, 16'h1234, 16'h3C00, 6'b000100, 16'h4000, 4'b0000};
        tbl[4]  = '{0, 16'h3C00, 16'h3C00, 16'h3C00, 6'b001101, 16'h0000, 4'b0000};
        tbl[5]  = '{1, 16'h3C00, 16'h4000, 16'h3C00, 6'b001110, 16'hBC00, 4'b0000};
        tbl[6]  = '{0, 16'h3C01, 16'h3C01, 16'h0000, 6'b001000, 16'h3C02, 4'b0001};
        tbl[7]  = '{0, 16'h3C01, 16'h3C01, 16'h0000, 6'b111000, 16'h3C03, 4'b0001};
        tbl[8]  = '{1, 16'h3C01, 16'h3C01, 16'h0000, 6'b011000, 16'h3C02, 4'b0001};
        tbl[9]  = '{0, 16'h0001, 16'h3800, 16'h0000, 6'b011000, 16'h0000, 4'b0011};
        tbl[10] = '{1, 16'h0001, 16'h3800, 16'h0000, 6'b111000, 16'h0001, 4'b0011};
        tbl[11] = '{0, 16'h3C00, 16'h3C00, 16'h7E00, 6'b001100, 16'h7E00, 4'b0000};
        tbl[12] = '{1, 16'h3C00, 16'h3C00, 16'h7C01, 6'b001100, 16'h7E00, 4'b1000};
        tbl[13] = '{0, 16'h7C00, 16'h3C00, 16'h7C00, 6'b001101, 16'h7E00, 4'b1000};
        tbl[14] = '{1, 16'h7BFF, 16'h7BFF, 16'h0000, 6'b011100, 16'h7C00, 4'b0101};
        tbl[15] = '{0, 16'h3C00, 16'h3C00, 16'h3C00, 6'b101101, 16'h8000, 4'b0000};

        // reset state, and no grant while reset is held
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        #1;
        chk("rst_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        step();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_sticky", bus.sticky_flags, 0);
        chk("rst_req_ready", bus.req_ready, 0);

        // both requesters continuously valid: alternating grants
        set_op(0, 16'h3C00, 16'h4000, 16'h3C00, 6'b001100);
        set_op(1, 16'h4000, 16'h4000, 16'h3C00, 6'b001100);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        got_id.delete();
        got_res.delete();
        for (int c = 0; c < 6; c++) begin
            chk("alt_grant", bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c >= 2) chk("alt_every_cycle", bus.rsp_valid, 1);
            collect();
            step();
        end
        bus.req_valid = '0;
        for (int n = 0; n < 4; n++) begin
            collect();
            step();
        end
        chk("alt_count", got_id.size(), 6);
        for (int k = 0; k < got_id.size(); k++) begin
            chk("alt_id", got_id[k], k % 2);
            chk("alt_res", got_res[k], (k % 2 == 0) ? 16'h4200 : 16'h4500);
        end

        // backpressure: two accepts fill A and B, then stall
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_ready", bus.req_ready,
                (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00);
            if (|bus.req_ready) acc++;
            if (c >= 2) begin
                chk("bp_hold_valid", bus.rsp_valid, 1);
                chk("bp_hold_id", bus.rsp_id, 0);
                chk("bp_hold_res", bus.rsp_result, 16'h4200);
            end
            step();
        end
        chk("bp_accepts", acc, 2);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        got_id.delete();
        got_res.delete();
        for (int n = 0; n < 5; n++) begin
            collect();
            step();
        end
        chk("bp_count", got_id.size(), 2);
        if (got_id.size() == 2) begin
            chk("bp_id0", got_id[0], 0);
            chk("bp_id1", got_id[1], 1);
            chk("bp_res0", got_res[0], 16'h4200);
            chk("bp_res1", got_res[1], 16'h4500);
        end
        chk("bp_no_dup", bus.rsp_valid, 0);

        // datapath vectors
        for (int i = 0; i < 16; i++)
            run_op(tbl[i].r, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].c,
                   tbl[i].er, tbl[i].ef, 1'b0);

        // clear coinciding with a handshake, then a lone clear
        run_op(0, 16'h0001, 16'h3800, 16'h0000, 6'b111000,
               16'h0001, 4'b0011, 1'b0);
        run_op(0, 16'h7C00, 16'h0000, 16'h0000, 6'b001100,
               16'h7E00, 4'b1000, 1'b1);
        chk("clr_hs_sticky0", bus.sticky_flags[3:0], 4'b1000);
        bus.flags_clr = 2'b01;
        step();
        bus.flags_clr = '0;
        st[0] = 4'h0;
        chk("clr_alone_sticky0", bus.sticky_flags[3:0], 4'b0000);
        chk("clr_alone_sticky1", bus.sticky_flags[7:4], st[1]);

        // reset with A and B both occupied and ptr pointing at requester 1
        bus.rsp_ready = 1'b0;
        set_op(0, 16'h3C00, 16'h4000, 16'h3C00, 6'b001100);
        bus.req_valid = 2'b01;
        #1;
        step();
        step();
        chk("mid_full", bus.rsp_valid, 1);
        chk("mid_stall", bus.req_ready, 0);
        bus.req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        st[0] = 4'h0;
        st[1] = 4'h0;
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_sticky", bus.sticky_flags, 0);
        chk("mid_rsp_result", bus.rsp_result, 0);
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("mid_dropped", bus.rsp_valid, 0);
        end
        set_op(1, 16'h4000, 16'h4000, 16'h3C00, 6'b001100);
        bus.req_valid = 2'b11;
        #1;
        chk("mid_first_grant", bus.req_ready, 2'b01);
        step();
        bus.req_valid = '0;
        step();
        chk("mid_first_valid", bus.rsp_valid, 1);
        chk("mid_first_id", bus.rsp_id, 0);
        chk("mid_first_res", bus.rsp_result, 16'h4200);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
